// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Double-buffered frame with per-digit enable, decimal point and leading-zero blanking.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIG   = 6,
    parameter int unsigned DWELL_CYC = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NUM_DIG-1:0]   disp_data,
    input  logic [NUM_DIG-1:0]     disp_en,
    input  logic [NUM_DIG-1:0]     dp_in,
    input  logic                   lz_blank,
    input  logic                   load,
    output logic                   load_ack,
    output logic [3:0]             bin_data,
    output logic [NUM_DIG-1:0]     seg_sel,
    output logic                   seg_dp,
    output logic                   frame_start
);

    localparam int unsigned MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned IW   = $clog2(NUM_DIG);

    typedef enum logic {
        BLANK,
        SHOW
    } state_e;

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;

    logic [4*NUM_DIG-1:0] sdata_q, ddata_q;
    logic [NUM_DIG-1:0]   sen_q, den_q;
    logic [NUM_DIG-1:0]   sdp_q, ddp_q;
    logic                 slz_q, dlz_q;
    logic                 pending_q;

    logic                 load_ack_q;
    logic                 frame_start_q;
    logic [3:0]           bin_data_q;
    logic [NUM_DIG-1:0]   seg_sel_q;
    logic                 seg_dp_q;

    logic                 blank_end, show_end, last_dig, wrap, commit;
    logic [IW-1:0]        idx_d;
    logic [4*NUM_DIG-1:0] dnext_data;
    logic [3:0]           nib_d;
    logic [NUM_DIG-1:0]   sel_d;
    logic                 dp_d;
    logic [NUM_DIG-1:0]   vis;
    logic                 zrun;

    // Scan from the top digit down; zrun stays set while every nibble so far is zero.
    always_comb begin
        vis  = '0;
        zrun = 1'b1;
        for (int unsigned k = 0; k < NUM_DIG; k++) begin
            zrun = zrun && (ddata_q[4*(NUM_DIG-1-k) +: 4] == 4'h0);
            vis[NUM_DIG-1-k] = den_q[NUM_DIG-1-k] &&
                               !(dlz_q && zrun && (k != NUM_DIG-1));
        end
    end

    always_comb begin
        blank_end  = (state_q == BLANK) && (cnt_q == CW'(BLANK_CYC - 1));
        show_end   = (state_q == SHOW)  && (cnt_q == CW'(DWELL_CYC - 1));
        last_dig   = (idx_q == IW'(NUM_DIG - 1));
        wrap       = show_end && last_dig;
        commit     = wrap && pending_q;
        idx_d      = show_end ? (last_dig ? '0 : idx_q + 1'b1) : idx_q;
        // Nibble for the next BLANK must see the frame being committed on this edge.
        dnext_data = commit ? sdata_q : ddata_q;
        nib_d      = '0;
        sel_d      = '1;
        dp_d       = 1'b1;
        for (int unsigned k = 0; k < NUM_DIG; k++) begin
            if (IW'(k) == idx_d) begin
                nib_d = dnext_data[4*k +: 4];
            end
            if ((IW'(k) == idx_q) && vis[k]) begin
                sel_d[k] = 1'b0;
                dp_d     = ~ddp_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BLANK;
            cnt_q         <= '0;
            idx_q         <= '0;
            sdata_q       <= '0;
            sen_q         <= '0;
            sdp_q         <= '0;
            slz_q         <= 1'b0;
            ddata_q       <= '0;
            den_q         <= '0;
            ddp_q         <= '0;
            dlz_q         <= 1'b0;
            pending_q     <= 1'b0;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            bin_data_q    <= '0;
            seg_sel_q     <= '1;
            seg_dp_q      <= 1'b1;
        end else begin
            load_ack_q    <= 1'b0;
            frame_start_q <= wrap;
            if (commit) begin
                ddata_q    <= sdata_q;
                den_q      <= sen_q;
                ddp_q      <= sdp_q;
                dlz_q      <= slz_q;
                pending_q  <= 1'b0;
                load_ack_q <= 1'b1;
            end
            // A load on the commit edge is staged after the copy and stays pending.
            if (load) begin
                sdata_q   <= disp_data;
                sen_q     <= disp_en;
                sdp_q     <= dp_in;
                slz_q     <= lz_blank;
                pending_q <= 1'b1;
            end
            case (state_q)
                BLANK: begin
                    if (blank_end) begin
                        state_q   <= SHOW;
                        cnt_q     <= '0;
                        seg_sel_q <= sel_d;
                        seg_dp_q  <= dp_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (show_end) begin
                        state_q    <= BLANK;
                        cnt_q      <= '0;
                        idx_q      <= idx_d;
                        seg_sel_q  <= '1;
                        seg_dp_q   <= 1'b1;
                        bin_data_q <= nib_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= BLANK;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;
    assign bin_data    = bin_data_q;
    assign seg_sel     = seg_sel_q;
    assign seg_dp      = seg_dp_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit seven-segment display.
- Holds a double-buffered frame of hex nibbles plus per-digit enable and decimal-point bits.
- Steps through the digits one at a time, with a blanking gap between digits to suppress ghosting.
- Drives the 4-bit hex value of the active digit to the hex-to-7-segment encoder, plus the active-low digit selects and the decimal point.
- Sits between the application logic and the encoder/display pins in the top level.

Parameters:
NUM_DIG, 6, number of digits scanned (2..8); digit 0 is least significant.
DWELL_CYC, 50000, clk cycles each digit is lit (1 ms at 50 MHz); must be >= 1.
BLANK_CYC, 500, clk cycles all digits are off before each digit is lit; must be >= 1.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous reset, active-high.
disp_data  in  4*NUM_DIG  nibble per digit; digit i at [4i+3:4i].
disp_en  in  NUM_DIG  per-digit enable; 0 means the digit is dark.
dp_in  in  NUM_DIG  per-digit decimal point, 1 means lit.
lz_blank  in  1  leading-zero blanking enable; sampled together with the data on load.
load  in  1  one-cycle strobe that captures disp_data, disp_en, dp_in and lz_blank into the staging buffer.
load_ack  out  1  one-cycle pulse when the staged frame becomes the displayed frame.
bin_data  out  4  nibble of the current digit, connected to the encoder input.
seg_sel  out  NUM_DIG  digit selects, active-low.
seg_dp  out  1  decimal point, active-low.
frame_start  out  1  one-cycle pulse on entry to BLANK for digit 0.

Behaviour:
- Reset (clk edge with rst=1):
  - state=BLANK, idx=0, cnt=0.
  - Staging and display buffers cleared: data 0, en 0, dp 0, lz 0. pending=0.
  - seg_sel all 1, seg_dp=1, bin_data=0, load_ack=0, frame_start=0.
  - rst wins over every simultaneous event; a pending load is discarded.
- FSM has two states, BLANK and SHOW. All outputs are registered.
  - BLANK: lasts exactly BLANK_CYC cycles. seg_sel all 1, seg_dp=1, bin_data = display nibble[idx]. At cnt=BLANK_CYC-1: cnt<=0, go to SHOW.
  - SHOW: lasts exactly DWELL_CYC cycles. seg_sel[idx]=0 only if the digit is visible (others stay 1). seg_dp = ~dp[idx] if visible, else 1. At cnt=DWELL_CYC-1: cnt<=0, idx<=(idx==NUM_DIG-1)?0:idx+1, go to BLANK.
  - Frame length = NUM_DIG*(BLANK_CYC+DWELL_CYC) cycles. The first SHOW after reset begins on the BLANK_CYC-th cycle after rst deasserts.
- Visibility: digit i is visible iff en[i]=1 and it is not leading-zero blanked.
  - With lz=1, digit i (i>=1) is blanked iff nibble[j]==0 for every j from i up to NUM_DIG-1.
  - Digit 0 is never lz-blanked.
  - Visibility uses only the display buffer.
- Loading and commit:
  - load=1: staging buffer <= inputs, pending<=1.
  - A load while pending overwrites staging; only one ack results.
  - Commit happens on the cycle the FSM moves from SHOW of idx NUM_DIG-1 to BLANK of idx 0: display buffer <= staging, pending<=0. load_ack=1 and frame_start=1 on the following cycle, coincident with the first BLANK cycle of digit 0.
  - If load and commit occur on the same edge, the commit copies the old staging contents. The new data is staged, pending stays 1, and it commits at the next frame boundary.
  - No commit means no ack. frame_start pulses every frame regardless of commit.
- bin_data changes only at BLANK entry, so the encoder output settles during the blank gap.
- Counter width: $clog2 of the larger of DWELL_CYC and BLANK_CYC, with a minimum of 1. idx width: $clog2(NUM_DIG).

Test Plan:
1. Reset/timing (NUM_DIG=4, DWELL_CYC=8, BLANK_CYC=2), no load -> seg_sel=4'b1111 and seg_dp=1 throughout. frame_start pulses every 40 cycles, the first one 40 cycles after rst falls. bin_data=0. load_ack never asserts.
2. Load 16'h1234, en=4'hF, dp=4'b0010 mid-frame -> exactly one load_ack, at the next frame boundary. In the following frame each digit is lit for exactly 8 cycles after 2 blank cycles, in the order 1110, 1101, 1011, 0111, with bin_data 4, 3, 2, 1 respectively. seg_dp=0 only while digit 1 is lit.
3. Load 16'h0050 with lz_blank=1 and en=4'hF -> digits 3 and 2 stay dark, digits 1 and 0 lit with bin_data 5 and 0. Repeat with 16'h0000 -> only digit 0 lit, showing 0.
4. Two loads (16'hAAAA, then 16'hBBBB) in one frame, the second on the exact commit cycle -> at that frame's boundary AAAA is displayed and one ack pulses. The next frame shows BBBB with a second ack.
5. rst asserted during SHOW of digit 2 with a pending load -> the next cycle has seg_sel all 1 and idx 0. No ack follows. Display stays blank until a new load and the next commit.
